imm_ext_stage: RTL
==================

# imm_ext_stage

Pipelined, parametrised successor to the single-cycle immediate extender, placed between instruction decode and execute in the pipelined core. It accepts an instruction word with an immediate-format select and a sideband tag over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN width, registered with one cycle of latency. It also provides a two-entry skid buffer, pipeline flush, illegal-format detection and a saturating illegal-format counter.

## Interface
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 5, width of sideband tag carried alongside the immediate (e.g. rd or ROB index); ≥1.
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_instr  input  25  instruction bits [31:7]; port bit i carries instruction bit i+7.
- in_immsrc  input  3  immediate format select.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts the entry.
- out_immext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the output entry.
- out_illegal  output  1  entry had an unsupported in_immsrc.
- illegal_cnt  output  16  count of illegal entries delivered downstream.

## Operation
- Format select (ins = instruction bit; s = ins[31] replicated to XLEN):
  - 000 I: s, ins[31:20].
  - 001 S: s, ins[31:25], ins[11:7].
  - 010 B: s, ins[7], ins[30:25], ins[11:8], 0.
  - 011 J: s, ins[19:12], ins[20], ins[30:21], 0.
  - 100 U: ins[31:12], 12'b0, sign-extended from bit 31 to XLEN (RV64 LUI semantics).
  - 101: see Configuration.
  - 110, 111: illegal; immext = 0, out_illegal = 1.
- Extension is computed combinationally at input and captured into the buffer on accept (in_valid && in_ready).
- Buffer: main register (drives outputs) plus one skid register.
  - in_ready = reset_n && !flush && !skid_valid. Registered state only, plus flush/reset gating.
  - Accept while main empty, or main draining this cycle: data goes to main.
  - Accept while main is full and stalled: data goes to skid.
  - Main drains (out_valid && out_ready) while skid full: skid moves to main, skid empties.
- Strict FIFO order; no entry dropped or duplicated except by flush/reset.
- flush: both entries invalidated next cycle. An input presented in the flush cycle is not accepted. An output handshake in the flush cycle still counts as delivered.
- illegal_cnt: +1 on each out_valid && out_ready && out_illegal. Saturates at 16'hFFFF. Cleared only by reset, not by flush.

## Timing
- Latency: accept in cycle N → out_valid in N+1 (main empty case).
- Throughput: one entry/cycle with out_ready held high.
- out_immext, out_tag, out_illegal are stable while out_valid && !out_ready.
- Reset (reset_n low at edge): out_valid=0, out_immext=0, out_tag=0, out_illegal=0, illegal_cnt=0, skid empty. in_ready=0 while reset_n low, 1 in the first cycle after release.
- Reset mid-operation discards all entries, including one being accepted.
- Simultaneous reset and flush: reset governs.
- Simultaneous flush and accept: accept suppressed via in_ready=0.

## Configuration
- IMM_CSR_EN defined: 101 is the Zicsr zimm format. immext = zero-extended ins[19:15], out_illegal=0.
- IMM_CSR_EN undefined: 101 is illegal, like 110/111.

## Test plan
- I/S decode, XLEN=32: instr 0xFFF00093 sel 000 → 0xFFFFFFFF. Then 0x00512423 sel 001 → 0x00000008. Each out_valid one cycle after accept.
- B/U/J, XLEN=64:
  - 0xFE000EE3 sel 010 → 0xFFFFFFFFFFFFFFFC.
  - 0x123450B7 sel 100 → 0x0000000012345000.
  - 0x800000B7 sel 100 → 0xFFFFFFFF80000000.
  - 0x0000006F sel 011 → 0.
- Backpressure: stream tags 1..6 with out_ready low for 3 cycles. in_ready drops after the 2nd entry. Outputs hold tag 1. All tags emerge in order 1..6 after release, none lost.
- Flush: two entries buffered, assert flush one cycle with in_valid high. Next cycle out_valid=0, in_ready=1, the offered entry is not accepted.
- Illegal/zimm: sel 111 → immext 0, out_illegal=1, illegal_cnt increments on handshake only. sel 101 with rs1 field 31 → 0x1F (IMM_CSR_EN) or illegal (undefined). Force 65540 illegal handshakes → illegal_cnt = 0xFFFF.
- Reset mid-stream: reset_n low one cycle with both entries full → all outputs 0. in_ready=0 during reset, 1 the following cycle.

Source files
------------

// File: rtl/imm_ext_stage.sv
// Pipelined immediate extender with a two-entry skid buffer; zimm format enabled by IMM_CSR_EN.
// Latency: one cycle from accept to out_valid when the main register is empty.
// Backpressure: in_ready depends only on skid occupancy, flush and reset, so it never waits on out_ready combinationally.
module imm_ext_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      in_instr,
   input  logic [2:0]       in_immsrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_immext,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic [15:0]      illegal_cnt
);

   typedef struct packed {
      logic [XLEN-1:0]  immext;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } entry_t;

   entry_t      main_q;
   entry_t      skid_q;
   entry_t      new_entry;
   logic        main_vld;
   logic        skid_vld;
   logic [31:0] imm32;
   logic        accept;
   logic        drain;

   // in_instr[k] holds instruction bit k+7, so ins[31] is in_instr[24].
   // Every legal format is built as a 32-bit value whose bit 31 is the
   // extension bit; zimm has a zero bit 31 and thus zero-extends too.
   always_comb begin
      imm32             = '0;
      new_entry.illegal = 1'b0;
      new_entry.tag     = in_tag;
      case (in_immsrc)
         3'b000: imm32 = {{20{in_instr[24]}}, in_instr[24:13]};
         3'b001: imm32 = {{20{in_instr[24]}}, in_instr[24:18], in_instr[4:0]};
         3'b010: imm32 = {{20{in_instr[24]}}, in_instr[0], in_instr[23:18],
                          in_instr[4:1], 1'b0};
         3'b011: imm32 = {{12{in_instr[24]}}, in_instr[12:5], in_instr[13],
                          in_instr[23:14], 1'b0};
         3'b100: imm32 = {in_instr[24:5], 12'b0};
`ifdef IMM_CSR_EN
         3'b101: imm32 = {27'b0, in_instr[12:8]};
`endif
         default: new_entry.illegal = 1'b1;
      endcase
      new_entry.immext        = {XLEN{imm32[31]}};
      new_entry.immext[31:0]  = imm32;
   end

   assign in_ready = reset_n && !flush && !skid_vld;
   assign accept   = in_valid && in_ready;
   assign drain    = main_vld && out_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         main_vld    <= 1'b0;
         skid_vld    <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
         illegal_cnt <= '0;
      end else begin
         // A handshake in a flush cycle still counts as delivered.
         if (drain && main_q.illegal && illegal_cnt != 16'hFFFF)
            illegal_cnt <= illegal_cnt + 16'd1;
         if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
         end else if (drain || !main_vld) begin
            if (skid_vld) begin
               main_q   <= skid_q;
               main_vld <= 1'b1;
               skid_vld <= 1'b0;
            end else if (accept) begin
               main_q   <= new_entry;
               main_vld <= 1'b1;
            end else begin
               main_vld <= 1'b0;
            end
         end else if (accept) begin
            skid_q   <= new_entry;
            skid_vld <= 1'b1;
         end
      end
   end

   assign out_valid   = main_vld;
   assign out_immext  = main_q.immext;
   assign out_tag     = main_q.tag;
   assign out_illegal = main_q.illegal;

endmodule
